// File: rtl/dice_roller_multi.sv
// dice_roller_multi: NUM_DICE x SIDES dice from LFSR rejection sampling,
// debounced roll button, timed rolling phase and multiplexed SSD scan.
module dice_roller_multi #(
  parameter int NUM_DICE        = 2,
  parameter int SIDES           = 6,
  parameter int DEBOUNCE_CYCLES = 1250000,
  parameter int ROLL_CYCLES     = 31250000,
  parameter int REFRESH_CYCLES  = 65536,
  parameter int SUM_W           = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                roll,
  input  logic                mode,
  output logic [6:0]          seg,
  output logic [NUM_DICE-1:0] an,
  output logic [SUM_W-1:0]    sum,
  output logic                busy,
  output logic                done
);

  localparam int DW  = (NUM_DICE > 1) ? $clog2(NUM_DICE) : 1;
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RCW = $clog2(ROLL_CYCLES + 1);
  localparam int RFW = $clog2(REFRESH_CYCLES + 1);

  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCW-1:0] RC_LAST = RCW'(ROLL_CYCLES - 1);
  localparam logic [RFW-1:0] RF_LAST = RFW'(REFRESH_CYCLES - 1);
  localparam logic [DW-1:0]  D_LAST  = DW'(NUM_DICE - 1);
  localparam logic [3:0]     SIDES_V = 4'(SIDES);
  localparam logic [6:0]     DASH    = 7'b1000000;

  typedef enum logic [1:0] {
    IDLE,
    ROLL,
    COMMIT
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q;
  logic             db_q, db_d;
  logic [DBW-1:0]   db_cnt_q, db_cnt_d;
  logic             roll_pulse;
  logic [15:0]      lfsr_q, lfsr_d;
  logic             mode_q, mode_d;
  logic [DW-1:0]    ptr_q, ptr_d;
  logic [DW-1:0]    idx_q, idx_d;
  logic [DW-1:0]    last_tgt;
  logic [RCW-1:0]   rc_q, rc_d;
  logic [3:0]       dice_q [NUM_DICE];
  logic [3:0]       dice_d [NUM_DICE];
  logic [SUM_W-1:0] sum_q, sum_d;
  logic             done_q, done_d;
  logic [RFW-1:0]   ref_q, ref_d;
  logic [DW-1:0]    dig_q, dig_d;
  logic [3:0]       samp;
  logic             accept;
  logic [3:0]       face;
  logic [3:0]       cur;
  logic             dash;
  logic [6:0]       glyph;

  // Debounce: flip only after DEBOUNCE_CYCLES straight disagreeing cycles
  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    if (sync2_q != db_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DBW'(1);
      end
    end
  end

  assign roll_pulse = db_d & ~db_q;

  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  assign samp   = {1'b0, lfsr_q[2:0]};
  assign accept = samp < SIDES_V;
  assign face   = samp + 4'd1;

  assign last_tgt = mode_q ? D_LAST : ptr_q;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    rc_d    = rc_q;
    dice_d  = dice_q;
    sum_d   = sum_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (roll_pulse) begin
          state_d = ROLL;
          mode_d  = mode;
          rc_d    = '0;
        end
      end
      ROLL: begin
        if (rc_q == RC_LAST) begin
          state_d = COMMIT;
          idx_d   = mode_q ? '0 : ptr_q;
        end else begin
          rc_d = rc_q + RCW'(1);
        end
      end
      COMMIT: begin
        if (accept) begin
          dice_d[idx_q] = face;
          if (idx_q == last_tgt) begin
            state_d = IDLE;
            done_d  = 1'b1;
            if (!mode_q) begin
              ptr_d = (ptr_q == D_LAST) ? '0 : ptr_q + DW'(1);
            end
          end else begin
            idx_d = idx_q + DW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Total is published only once the whole target set is written
    if (done_d) begin
      sum_d = '0;
      for (int i = 0; i < NUM_DICE; i++) begin
        sum_d = sum_d + SUM_W'(dice_d[i]);
      end
    end
  end

  always_comb begin
    ref_d = ref_q + RFW'(1);
    dig_d = dig_q;
    if (ref_q == RF_LAST) begin
      ref_d = '0;
      dig_d = (dig_q == D_LAST) ? '0 : dig_q + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      db_q     <= 1'b0;
      db_cnt_q <= '0;
      lfsr_q   <= 16'hACE1;
      state_q  <= IDLE;
      mode_q   <= 1'b0;
      ptr_q    <= '0;
      idx_q    <= '0;
      rc_q     <= '0;
      dice_q   <= '{default: '0};
      sum_q    <= '0;
      done_q   <= 1'b0;
      ref_q    <= '0;
      dig_q    <= '0;
    end else begin
      sync1_q  <= roll;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      db_cnt_q <= db_cnt_d;
      lfsr_q   <= lfsr_d;
      state_q  <= state_d;
      mode_q   <= mode_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      rc_q     <= rc_d;
      dice_q   <= dice_d;
      sum_q    <= sum_d;
      done_q   <= done_d;
      ref_q    <= ref_d;
      dig_q    <= dig_d;
    end
  end

  always_comb begin
    cur  = dice_q[dig_q];
    dash = (state_q == ROLL) && (mode_q || (dig_q == ptr_q));
    unique case (cur)
      4'd1:    glyph = 7'b0000110;
      4'd2:    glyph = 7'b1011011;
      4'd3:    glyph = 7'b1001111;
      4'd4:    glyph = 7'b1100110;
      4'd5:    glyph = 7'b1101101;
      4'd6:    glyph = 7'b1111101;
      4'd7:    glyph = 7'b0000111;
      4'd8:    glyph = 7'b1111111;
      default: glyph = 7'b0000000;
    endcase
    seg = dash ? DASH : glyph;
  end

  assign an   = NUM_DICE'(1) << dig_q;
  assign sum  = sum_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_dice_roller_multi.sv
// tb_dice_roller_multi: directed + randomized rolls checked every cycle
// against a behavioural dice/LFSR/display model.
module tb_dice_roller_multi;

  localparam int ND = 2;
  localparam int SD = 6;
  localparam int DB = 4;
  localparam int RC = 8;
  localparam int RF = 4;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          roll = 1'b0;
  logic          mode = 1'b0;
  logic [6:0]    seg;
  logic [ND-1:0] an;
  logic [SW-1:0] sum;
  logic          busy;
  logic          done;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] m_lfsr;
  int          k;
  int          m_dice[ND];
  int          m_ptr;
  int          m_sum;

  dice_roller_multi #(
    .NUM_DICE(ND),
    .SIDES(SD),
    .DEBOUNCE_CYCLES(DB),
    .ROLL_CYCLES(RC),
    .REFRESH_CYCLES(RF),
    .SUM_W(SW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .roll(roll),
    .mode(mode),
    .seg(seg),
    .an(an),
    .sum(sum),
    .busy(busy),
    .done(done)
  );

  always #4 clk = ~clk;

  // Multiply by x modulo x^16+x^14+x^13+x^11+1 (bit-reversed Galois form)
  function automatic logic [15:0] lstep(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic logic [6:0] pat(input int v);
    case (v)
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      m_lfsr = lstep(m_lfsr);
      k++;
    end else begin
      m_lfsr = 16'hACE1;
      k = 0;
    end
    #1;
  endtask

  task automatic view(input string tag, input logic [ND-1:0] dmask,
                      input int dv[ND], input bit be, input bit de,
                      input int se);
    int d;
    d = (k / RF) % ND;
    chk({tag, "/an"}, 32'(an), 32'(1 << d));
    chk({tag, "/seg"}, 32'(seg),
        32'(dmask[d] ? 7'b1000000 : pat(dv[d])));
    chk({tag, "/busy"}, 32'(busy), 32'(be));
    chk({tag, "/done"}, 32'(done), 32'(de));
    chk({tag, "/sum"}, 32'(sum), 32'(se));
  endtask

  task automatic idle_ticks(input int n);
    roll = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      view("idle", '0, m_dice, 1'b0, 1'b0, m_sum);
    end
  endtask

  task automatic do_roll(input bit md, input bit second, input bit rst_mid);
    logic [15:0]   s;
    logic [ND-1:0] tmask;
    int            wd[ND];
    int            wv[ND];
    int            we[ND];
    int            cur[ND];
    int            nt;
    int            c;
    int            n;
    int            nsum;
    bit            stop;
    mode = md;
    for (int i = 1; i <= 6; i++) begin
      roll = (i <= 4);
      tick();
      if (i < 6) view("press", '0, m_dice, 1'b0, 1'b0, m_sum);
    end
    tmask = md ? '1 : ND'(1) << m_ptr;
    s = m_lfsr;
    for (int i = 0; i < RC; i++) s = lstep(s);
    c  = 0;
    nt = 0;
    for (int j = 0; j < ND; j++) begin
      if (md || j == m_ptr) begin
        while (int'(s[2:0]) >= SD) begin
          s = lstep(s);
          c++;
        end
        wd[nt] = j;
        wv[nt] = int'(s[2:0]) + 1;
        we[nt] = RC + 1 + c;
        nt++;
        s = lstep(s);
        c++;
      end
    end
    n = c;
    cur = m_dice;
    for (int j = 0; j < nt; j++) cur[wd[j]] = wv[j];
    nsum = 0;
    for (int j = 0; j < ND; j++) nsum += cur[j];
    cur = m_dice;
    view("roll0", tmask, cur, 1'b1, 1'b0, m_sum);
    stop = 1'b0;
    for (int t = 1; t <= RC + n && !stop; t++) begin
      roll = second && (6 + t >= 9);
      mode = 1'($urandom);
      tick();
      for (int j = 0; j < nt; j++) if (we[j] == t) cur[wd[j]] = wv[j];
      view(t < RC ? "rolling" : "commit", t < RC ? tmask : '0, cur,
           t < RC + n, t == RC + n, t == RC + n ? nsum : m_sum);
      if (rst_mid && t == we[0]) stop = 1'b1;
    end
    roll = 1'b0;
    if (stop) begin
      rst_n = 1'b0;
      #1;
      foreach (m_dice[j]) m_dice[j] = 0;
      m_sum  = 0;
      m_ptr  = 0;
      k      = 0;
      m_lfsr = 16'hACE1;
      view("rstmid", '0, m_dice, 1'b0, 1'b0, 0);
      tick();
      view("rsthold", '0, m_dice, 1'b0, 1'b0, 0);
      tick();
      rst_n = 1'b1;
    end else begin
      m_dice = cur;
      m_sum  = nsum;
      if (!md) m_ptr = (m_ptr + 1) % ND;
    end
  endtask

  initial begin
    m_lfsr = 16'hACE1;
    k      = 0;
    m_ptr  = 0;
    m_sum  = 0;
    foreach (m_dice[j]) m_dice[j] = 0;
    tick();
    tick();
    rst_n = 1'b1;
    view("reset", '0, m_dice, 1'b0, 1'b0, 0);
    idle_ticks(8);

    for (int i = 0; i < 20; i++) begin
      roll = ((i / 2) % 2 == 0);
      tick();
      view("bounce", '0, m_dice, 1'b0, 1'b0, m_sum);
    end
    do_roll(1'b0, 1'b0, 1'b0);
    idle_ticks($urandom_range(7, 15));
    do_roll(1'b0, 1'b0, 1'b0);
    idle_ticks($urandom_range(7, 15));
    do_roll(1'b0, 1'b0, 1'b0);
    idle_ticks($urandom_range(7, 15));

    do_roll(1'b1, 1'b0, 1'b0);
    idle_ticks($urandom_range(7, 15));
    do_roll(1'b1, 1'b1, 1'b0);
    idle_ticks($urandom_range(7, 15));

    do_roll(1'b1, 1'b0, 1'b1);
    idle_ticks($urandom_range(3, 9));
    do_roll(1'b0, 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      idle_ticks($urandom_range(7, 20));
      do_roll(1'($urandom), 1'($urandom), 1'b0);
    end
    idle_ticks(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
